speed_serial_tx: RTL and testbench



---
 rtl/speed_serial_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_speed_serial_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/speed_serial_tx.sv
// speed_serial_tx
//
// Framed serial transmitter feeding the display board's receiver. Each byte
// goes out as: start bit (low), 8 data bits LSB first, stop bit (high), then
// GAP_BITS idle-high bit times. Every bit lasts CLKS_PER_BIT cycles.
//
// A one-deep holding slot accepts a new measurement at any time, so a value
// arriving mid-frame is not lost. Only the newest value is kept: overwriting
// a slot that has not been sent yet pulses overflow. After REFRESH_CYCLES
// quiet cycles in IDLE the last byte sent is queued again, so a freshly reset
// display picks up the current speed (REFRESH_CYCLES = 0 disables this).
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   in_data   speed byte, sampled on the edge where in_valid is high
//   in_valid  single-cycle strobe
//   serial    registered frame line, idles high
//   busy      high whenever a frame (including its gap) is in progress
//   overflow  one-cycle pulse when an unsent pending byte is overwritten

module speed_serial_tx #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int GAP_BITS       = 2,
  parameter int REFRESH_CYCLES = 180000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       serial,
  output logic       busy,
  output logic       overflow
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  // The bit index counts data bits in DATA and gap bits in GAP.
  localparam int IDX_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam int REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);
  localparam logic [REF_W-1:0] REF_LAST  =
    REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam bit REF_EN = (REFRESH_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [7:0]       r_pend_data;
  logic             r_pend_full;
  logic [7:0]       r_shift;
  logic [7:0]       r_last_data;
  logic             r_has_last;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [REF_W-1:0] r_ref_cnt;
  logic             r_serial;
  logic             r_overflow;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [7:0]       w_shift_next;
  logic             w_serial_next;
  logic             w_load;
  logic             w_bit_end;
  logic             w_ref_run;
  logic             w_ref_fire;

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Refresh only counts while truly idle with something to repeat; a fresh
  // strobe takes priority and restarts the quiet period.
  assign w_ref_run  = REF_EN && (r_state == S_IDLE) && !r_pend_full &&
                      r_has_last && !in_valid;
  assign w_ref_fire = w_ref_run && (r_ref_cnt == REF_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + CNT_W'(1);
    w_idx_next    = r_idx;
    w_shift_next  = r_shift;
    w_load        = 1'b0;
    w_serial_next = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        w_idx_next = '0;
        if (r_pend_full) begin
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_idx == DATA_LAST) begin
            w_idx_next   = '0;
            w_state_next = S_STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == GAP_LAST) begin
            w_idx_next = '0;
            // Back-to-back frame: the next start bit follows the gap directly.
            if (r_pend_full) begin
              w_load       = 1'b1;
              w_state_next = S_START;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_idx_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_next = r_pend_data;
    end

    // The line is registered, so it is derived from the state being entered.
    case (w_state_next)
      S_START: w_serial_next = 1'b0;
      S_DATA:  w_serial_next = w_shift_next[0];
      default: w_serial_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_data <= '0;
      r_pend_full <= 1'b0;
      r_shift     <= '0;
      r_last_data <= '0;
      r_has_last  <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ref_cnt   <= '0;
      r_serial    <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_serial <= w_serial_next;

      if (w_ref_run && !w_ref_fire) begin
        r_ref_cnt <= r_ref_cnt + REF_W'(1);
      end else begin
        r_ref_cnt <= '0;
      end

      // A strobe always lands in the slot. If the slot empties on the same
      // edge, its old value has just moved to the shifter and nothing is lost.
      if (in_valid) begin
        r_pend_data <= in_data;
        r_pend_full <= 1'b1;
        r_overflow  <= r_pend_full && !w_load;
      end else begin
        r_overflow <= 1'b0;
        if (w_load) begin
          r_pend_full <= 1'b0;
        end else if (w_ref_fire) begin
          r_pend_data <= r_last_data;
          r_pend_full <= 1'b1;
        end
      end

      if (w_load) begin
        r_last_data <= r_pend_data;
        r_has_last  <= 1'b1;
      end
    end
  end

  assign serial   = r_serial;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_speed_serial_tx.sv
// tb_speed_serial_tx
//
// Directed bench for speed_serial_tx at CLKS_PER_BIT=16, GAP_BITS=2 and
// REFRESH_CYCLES=1000. Inputs change and outputs are sampled on the falling
// clock edge; the DUT acts on the rising edge.

module tb_speed_serial_tx;

  localparam int CPB   = 16;
  localparam int GAP   = 2;
  localparam int REF   = 1000;
  localparam int FRAME = (10 + GAP) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       serial;
  logic       busy;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int ovf_cnt = 0;

  speed_serial_tx #(
    .CLKS_PER_BIT  (CPB),
    .GAP_BITS      (GAP),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .serial  (serial),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Cycles with overflow high, sampled mid-cycle.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_serial", serial, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a falling edge; the capturing rising edge is the next one.
  task automatic strobe(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait for the start bit; waited = falling edges until it is seen.
  task automatic wait_start(input string tag, input int limit, output int waited);
    waited = 0;
    while (serial !== 1'b0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_seen"}, serial, 0);
  endtask

  // Entered on the first falling edge of the start bit; checks every cycle
  // of the frame and returns on the falling edge one frame later.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    int  bad_line = 0;
    int  bad_busy = 0;
    int  k;
    logic e;
    for (int j = 0; j < FRAME; j++) begin
      k = j / CPB;
      if (k == 0)      e = 1'b0;
      else if (k <= 8) e = b[k-1];
      else             e = 1'b1;
      if (serial !== e) begin
        bad_line++;
        if (bad_line == 1)
          $display("FAIL %s_bitcycle: cycle %0d observed %b expected %b", tag, j, serial, e);
      end
      if (busy !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    check({tag, "_line"}, bad_line, 0);
    check({tag, "_busy"}, bad_busy, 0);
  endtask

  // Line must stay idle and busy low for n cycles.
  task automatic expect_idle(input string tag, input int n);
    int lows  = 0;
    int busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (serial !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check({tag, "_line_low_cycles"}, lows, 0);
    check({tag, "_busy_cycles"}, busys, 0);
  endtask

  int w;
  int ovf_base;

  initial begin
    // 1: single 0xA5 frame, one idle cycle of latency, busy 192 cycles.
    do_reset();
    ovf_base = ovf_cnt;
    strobe(8'hA5);
    wait_start("a5", 5, w);
    check("a5_latency", w, 1);
    expect_frame("a5", 8'hA5);
    check("a5_busy_fall", busy, 0);
    check("a5_line_idle", serial, 1);
    check("a5_no_ovf", ovf_cnt - ovf_base, 0);

    // 2: 0x3C then 0x7F 50 cycles later, frames back-to-back.
    do_reset();
    ovf_base = ovf_cnt;
    strobe(8'h3C);
    wait_start("3c", 5, w);
    fork
      expect_frame("3c", 8'h3C);
      begin
        repeat (50) @(negedge clk);
        strobe(8'h7F);
      end
    join
    check("7f_back_to_back", serial, 0);
    expect_frame("7f", 8'h7F);
    check("7f_busy_fall", busy, 0);
    check("b2b_no_ovf", ovf_cnt - ovf_base, 0);

    // 3: two strobes during one frame, the older pending byte is dropped.
    do_reset();
    ovf_base = ovf_cnt;
    strobe(8'h01);
    wait_start("01", 5, w);
    fork
      expect_frame("01", 8'h01);
      begin
        repeat (20) @(negedge clk);
        strobe(8'h10);
        repeat (29) @(negedge clk);
        strobe(8'h20);
        check("ovf_pulse", overflow, 1);
      end
    join
    check("ovf_one_cycle", ovf_cnt - ovf_base, 1);
    check("20_back_to_back", serial, 0);
    expect_frame("20", 8'h20);
    expect_idle("after_20", 300);

    // 4: strobe on the edge that ends the gap while the slot is full.
    do_reset();
    ovf_base = ovf_cnt;
    strobe(8'h11);
    wait_start("11", 5, w);
    fork
      expect_frame("11", 8'h11);
      begin
        repeat (10) @(negedge clk);
        strobe(8'h22);
      end
      begin
        repeat (FRAME - 1) @(negedge clk);
        strobe(8'h33);
      end
    join
    check("22_back_to_back", serial, 0);
    expect_frame("22", 8'h22);
    check("33_back_to_back", serial, 0);
    expect_frame("33", 8'h33);
    check("gap_edge_no_ovf", ovf_cnt - ovf_base, 0);

    // 5: no refresh before a byte is sent; afterwards 0x42 every 1193 cycles.
    do_reset();
    expect_idle("no_byte_yet", 1500);
    strobe(8'h42);
    wait_start("42", 5, w);
    expect_frame("42", 8'h42);
    wait_start("ref1", 1100, w);
    check("ref1_delay", w, REF + 1);
    expect_frame("ref1", 8'h42);
    wait_start("ref2", 1100, w);
    check("ref2_delay", w, REF + 1);
    expect_frame("ref2", 8'h42);

    // 6: asynchronous reset in the middle of data bit 3 (a low bit of 0xA5).
    do_reset();
    strobe(8'hA5);
    wait_start("mid", 5, w);
    repeat (70) @(negedge clk);
    check("mid_bit3_low", serial, 0);
    rst_n = 1'b0;
    #1;
    check("async_serial", serial, 1);
    check("async_busy", busy, 0);
    check("async_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("after_async", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
